// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: widths, HALT encoding,
// fetch FSM states and the IF/ID register layout used by fetch and decode.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic [0:0] {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus2;
  } ifid_reg_t;

  // Next sequential instruction address; wraps modulo 2^16.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 16'd2;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the zero-latency instruction memory and
// fills the IF/ID register, honouring redirect > stall > fetch and HALT.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        halted,
  output logic        misaligned,
  output logic [15:0] fetch_count
);
  import cpu_pkg::*;

  fetch_state_t r_state;
  ifid_reg_t    r_ifid;
  logic [15:0]  r_pc;
  logic         r_halted;
  logic         r_misaligned;
  logic [15:0]  r_fetch_count;

  // Fetch FSM, PC, IF/ID register and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FS_RUN;
      r_pc          <= RESET_PC;
      r_ifid        <= '0;
      r_halted      <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= 16'h0000;
    end else if (redirect_valid) begin
      // A redirect also discards a HALT fetched down the wrong path.
      r_state      <= FS_RUN;
      r_pc         <= {redirect_target[15:1], 1'b0};
      r_ifid.valid <= 1'b0;
      r_halted     <= 1'b0;
      r_misaligned <= r_misaligned | redirect_target[0];
    end else if (stall) begin
      r_state <= r_state;
    end else begin
      case (r_state)
        FS_RUN: begin
          r_ifid.valid    <= 1'b1;
          r_ifid.instr    <= imem_data;
          r_ifid.pc       <= r_pc;
          r_ifid.pc_plus2 <= pc_inc(r_pc);
          r_fetch_count   <= sat_inc16(r_fetch_count);
          if (imem_data == HALT_WORD) begin
            r_state  <= FS_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_pc <= pc_inc(r_pc);
          end
        end
        FS_HALTED: begin
          r_ifid.valid <= 1'b0;
        end
        default: begin
          r_state <= FS_RUN;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign if_valid    = r_ifid.valid;
  assign if_instr    = r_ifid.instr;
  assign if_pc       = r_ifid.pc;
  assign if_pc_plus2 = r_ifid.pc_plus2;
  assign halted      = r_halted;
  assign misaligned  = r_misaligned;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit, including a second
// instance with RESET_PC = 16'hFFFE for PC wrap-around.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] imem_addr, imem_data;
  logic        if_valid, halted, misaligned;
  logic [15:0] if_instr, if_pc, if_pc_plus2, fetch_count;

  logic        b_stall = 1'b0;
  logic        b_redir = 1'b0;
  logic [15:0] b_target = 16'h0000;
  logic [15:0] b_imem_addr, b_imem_data;
  logic        b_if_valid, b_halted, b_misaligned;
  logic [15:0] b_if_instr, b_if_pc, b_if_pc_plus2, b_fetch_count;

  logic [15:0] rom [0:31];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_data   = (imem_addr < 16'h0040) ? rom[imem_addr[5:1]] : 16'h5A5A;
  assign b_imem_data = (b_imem_addr == 16'hFFFE) ? 16'h4321 : 16'h0101;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
    .halted(halted), .misaligned(misaligned), .fetch_count(fetch_count)
  );

  instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .reset(reset), .imem_addr(b_imem_addr), .imem_data(b_imem_data),
    .stall(b_stall), .redirect_valid(b_redir), .redirect_target(b_target),
    .if_valid(b_if_valid), .if_instr(b_if_instr), .if_pc(b_if_pc), .if_pc_plus2(b_if_pc_plus2),
    .halted(b_halted), .misaligned(b_misaligned), .fetch_count(b_fetch_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i);
    rom[0]  = 16'hFE21;
    rom[2]  = 16'h2388;
    rom[3]  = 16'h149A;
    rom[17] = 16'h6704;
    rom[31] = 16'h0000;

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
    tick(); tick();
    chk("rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_pc2", if_pc_plus2, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    chk("rst_mis", {15'd0, misaligned}, 16'h0000);
    chk("rst_cnt", fetch_count, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("b_rst_addr", b_imem_addr, 16'hFFFE);

    reset = 1'b0;
    tick();
    chk("f1_valid", {15'd0, if_valid}, 16'h0001);
    chk("f1_pc", if_pc, 16'h0000);
    chk("f1_instr", if_instr, 16'hFE21);
    chk("b_wrap_addr", b_imem_addr, 16'h0000);
    chk("b_wrap_pc", b_if_pc, 16'hFFFE);
    chk("b_wrap_pc2", b_if_pc_plus2, 16'h0000);
    chk("b_wrap_instr", b_if_instr, 16'h4321);
    tick();
    chk("f2_instr", if_instr, 16'h1001);
    tick();
    chk("f3_pc", if_pc, 16'h0004);
    chk("f3_instr", if_instr, 16'h2388);
    chk("f3_pc2", if_pc_plus2, 16'h0006);

    stall = 1'b1;
    tick(); tick(); tick();
    chk("stall_addr", imem_addr, 16'h0006);
    chk("stall_instr", if_instr, 16'h2388);
    chk("stall_cnt", fetch_count, 16'h0003);
    stall = 1'b0;
    tick();
    chk("unstall_instr", if_instr, 16'h149A);
    chk("unstall_pc", if_pc, 16'h0006);
    chk("unstall_cnt", fetch_count, 16'h0004);

    redirect_valid = 1'b1; redirect_target = 16'h0022; stall = 1'b1;
    tick();
    chk("redir_valid", {15'd0, if_valid}, 16'h0000);
    chk("redir_addr", imem_addr, 16'h0022);
    chk("redir_hold", if_instr, 16'h149A);
    redirect_valid = 1'b0; stall = 1'b0;
    tick();
    chk("redir_instr", if_instr, 16'h6704);
    chk("redir_pc", if_pc, 16'h0022);
    chk("redir_cnt", fetch_count, 16'h0005);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    chk("pre_halt_cnt", fetch_count, 16'd31);
    chk("pre_halt_h", {15'd0, halted}, 16'h0000);
    tick();
    chk("halt_instr", if_instr, 16'h0000);
    chk("halt_valid", {15'd0, if_valid}, 16'h0001);
    chk("halt_flag", {15'd0, halted}, 16'h0001);
    chk("halt_addr", imem_addr, 16'h003E);
    chk("halt_cnt", fetch_count, 16'd32);
    stall = 1'b1;
    tick();
    chk("halt_stall_valid", {15'd0, if_valid}, 16'h0001);
    stall = 1'b0;
    tick();
    chk("halted_valid", {15'd0, if_valid}, 16'h0000);
    chk("halted_cnt", fetch_count, 16'd32);
    chk("halted_addr", imem_addr, 16'h003E);
    tick();
    chk("halted_flag2", {15'd0, halted}, 16'h0001);

    redirect_valid = 1'b1; redirect_target = 16'h0023;
    tick();
    chk("odd_mis", {15'd0, misaligned}, 16'h0001);
    chk("odd_addr", imem_addr, 16'h0022);
    chk("odd_halted", {15'd0, halted}, 16'h0000);
    redirect_valid = 1'b0;
    tick();
    chk("resume_instr", if_instr, 16'h6704);
    chk("resume_valid", {15'd0, if_valid}, 16'h0001);
    chk("resume_cnt", fetch_count, 16'd33);
    chk("resume_mis", {15'd0, misaligned}, 16'h0001);

    stall = 1'b1; reset = 1'b1;
    tick();
    chk("mid_rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("mid_rst_instr", if_instr, 16'h0000);
    chk("mid_rst_pc", if_pc, 16'h0000);
    chk("mid_rst_pc2", if_pc_plus2, 16'h0000);
    chk("mid_rst_mis", {15'd0, misaligned}, 16'h0000);
    chk("mid_rst_cnt", fetch_count, 16'h0000);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    chk("b_mid_rst_addr", b_imem_addr, 16'hFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
